run_search_ctrl: RTL and testbench

RUN_SEARCH_CTRL -- requirements
Module: run_search_ctrl

---
 rtl/run_search_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_run_search_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_search_ctrl.sv
// run_search_ctrl: rotate-scan / confirm / drive controller that searches for a
// target frequency band and drives toward it.
// Optional feature macro: SCAN_DIR_TOGGLE_EN -- when defined, every DRIVE->SCAN
// re-entry inverts the scan rotation direction.
module run_search_ctrl #(
  parameter logic [7:0]  STABLE_CNT   = 8'd16,
  parameter logic [7:0]  LOST_CNT     = 8'd64,
  parameter logic [23:0] SCAN_TIMEOUT = 24'd5000000,
  parameter logic [23:0] DRIVE_TIME   = 24'd10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] freq_state,
  input  logic [3:0] target_state,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [2:0] state_dbg
);

  localparam int unsigned TMR_W = 24;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  localparam logic [3:0] BAND_MIN = 4'd7;
  localparam logic [3:0] BAND_MAX = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_DRIVE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   scan_tmr_q, scan_tmr_d;
  logic [TMR_W-1:0]   drive_tmr_q, drive_tmr_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic               found_q, found_d;
  logic [1:0]         motor_l_q, motor_l_d;
  logic [1:0]         motor_r_q, motor_r_d;
  logic               busy_q;
  logic               done_q;

  logic               match_c;
  logic               target_ok_c;
  logic               scan_rev_c;
  logic [TMR_W-1:0]   scan_tmr_inc_c;
  logic [TMR_W-1:0]   drive_tmr_inc_c;
  logic [CNT_W-1:0]   match_cnt_inc_c;
  logic [CNT_W-1:0]   lost_cnt_inc_c;

`ifdef SCAN_DIR_TOGGLE_EN
  logic               dir_q, dir_d;
`endif

  // Compare and saturating-increment helpers shared by the state logic
  always_comb begin
    match_c         = (freq_state == target_state);
    target_ok_c     = (target_state >= BAND_MIN) && (target_state <= BAND_MAX);
    scan_tmr_inc_c  = (scan_tmr_q == {TMR_W{1'b1}}) ? scan_tmr_q : scan_tmr_q + TMR_W'(1);
    drive_tmr_inc_c = (drive_tmr_q == {TMR_W{1'b1}}) ? drive_tmr_q : drive_tmr_q + TMR_W'(1);
    match_cnt_inc_c = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q : match_cnt_q + CNT_W'(1);
    lost_cnt_inc_c  = (lost_cnt_q == {CNT_W{1'b1}}) ? lost_cnt_q : lost_cnt_q + CNT_W'(1);
  end

  // Next-state, timer, counter and result logic; abort overrides everything
  always_comb begin
    state_d     = state_q;
    scan_tmr_d  = scan_tmr_q;
    drive_tmr_d = drive_tmr_q;
    match_cnt_d = match_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    found_d     = found_q;
`ifdef SCAN_DIR_TOGGLE_EN
    dir_d       = dir_q;
`endif

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && target_ok_c) begin
            state_d    = ST_SCAN;
            scan_tmr_d = '0;
            found_d    = 1'b0;
`ifdef SCAN_DIR_TOGGLE_EN
            dir_d      = 1'b0;
`endif
          end
        end

        ST_SCAN: begin
          scan_tmr_d = scan_tmr_inc_c;
          if (match_c) begin
            // A single required match skips the confirm phase entirely
            if (STABLE_CNT <= 8'd1) begin
              state_d     = ST_DRIVE;
              drive_tmr_d = '0;
              lost_cnt_d  = '0;
            end else begin
              state_d     = ST_CONFIRM;
              match_cnt_d = CNT_W'(1);
            end
          end else if (scan_tmr_q >= SCAN_TIMEOUT - 24'd1) begin
            state_d = ST_DONE;
            found_d = 1'b0;
          end
        end

        ST_CONFIRM: begin
          if (match_c) begin
            match_cnt_d = match_cnt_inc_c;
            if (match_cnt_q >= STABLE_CNT - 8'd1) begin
              state_d     = ST_DRIVE;
              drive_tmr_d = '0;
              lost_cnt_d  = '0;
            end
          end else begin
            // Scan timer is kept so a flickering target cannot extend the search
            state_d = ST_SCAN;
          end
        end

        ST_DRIVE: begin
          drive_tmr_d = drive_tmr_inc_c;
          lost_cnt_d  = match_c ? '0 : lost_cnt_inc_c;
          if (drive_tmr_q >= DRIVE_TIME - 24'd1) begin
            state_d = ST_DONE;
            found_d = 1'b1;
          end else if (!match_c && (lost_cnt_q >= LOST_CNT - 8'd1)) begin
            state_d    = ST_SCAN;
            scan_tmr_d = '0;
            lost_cnt_d = '0;
`ifdef SCAN_DIR_TOGGLE_EN
            dir_d      = ~dir_q;
`endif
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Scan rotation sense for the upcoming state
`ifdef SCAN_DIR_TOGGLE_EN
  assign scan_rev_c = dir_d;
`else
  assign scan_rev_c = 1'b0;
`endif

  // Motor command for the upcoming state, registered so outputs track state_q
  always_comb begin
    motor_l_d = MOT_STOP;
    motor_r_d = MOT_STOP;
    case (state_d)
      ST_SCAN: begin
        motor_l_d = scan_rev_c ? MOT_FWD : MOT_REV;
        motor_r_d = scan_rev_c ? MOT_REV : MOT_FWD;
      end
      ST_DRIVE: begin
        motor_l_d = MOT_FWD;
        motor_r_d = MOT_FWD;
      end
      default: begin
        motor_l_d = MOT_STOP;
        motor_r_d = MOT_STOP;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      scan_tmr_q  <= '0;
      drive_tmr_q <= '0;
      match_cnt_q <= '0;
      lost_cnt_q  <= '0;
      found_q     <= 1'b0;
      motor_l_q   <= MOT_STOP;
      motor_r_q   <= MOT_STOP;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_tmr_q  <= scan_tmr_d;
      drive_tmr_q <= drive_tmr_d;
      match_cnt_q <= match_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      found_q     <= found_d;
      motor_l_q   <= motor_l_d;
      motor_r_q   <= motor_r_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

`ifdef SCAN_DIR_TOGGLE_EN
  // Scan direction register, back to default on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign motor_l   = motor_l_q;
  assign motor_r   = motor_r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_run_search_ctrl.sv
// Scoreboard bench for run_search_ctrl with small timing parameters.
module tb_run_search_ctrl;

  localparam int unsigned CLK_HALF = 5;

`ifdef SCAN_DIR_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_CONF = 3'd2;
  localparam logic [2:0] S_DRV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic       clk;
  logic       rst_n;
  logic [3:0] freq_state;
  logic [3:0] target_state;
  logic       start;
  logic       abort;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] state_dbg;

  run_search_ctrl #(
    .STABLE_CNT   (8'd4),
    .LOST_CNT     (8'd3),
    .SCAN_TIMEOUT (24'd100),
    .DRIVE_TIME   (24'd50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freq_state   (freq_state),
    .target_state (target_state),
    .start        (start),
    .abort        (abort),
    .motor_l      (motor_l),
    .motor_r      (motor_r),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .state_dbg    (state_dbg)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [2:0] st;
    logic [1:0] ml;
    logic [1:0] mr;
    logic       bz;
    logic       dn;
    logic       fd;
  } exp_t;

  typedef struct {
    int   cyc;
    logic fd;
  } done_t;

  exp_t  exp_q[$];
  done_t done_q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expected output snapshot for a given cycle
  task automatic expect_at(input int c, input string nm, input logic [2:0] st,
                           input logic rev, input logic dn, input logic fd);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.st  = st;
    e.dn  = dn;
    e.fd  = fd;
    e.bz  = (st != S_IDLE);
    case (st)
      S_SCAN: begin
        e.ml = rev ? 2'b01 : 2'b10;
        e.mr = rev ? 2'b10 : 2'b01;
      end
      S_DRV: begin
        e.ml = 2'b01;
        e.mr = 2'b01;
      end
      default: begin
        e.ml = 2'b00;
        e.mr = 2'b00;
      end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input int c, input logic fd);
    done_t d;
    d.cyc = c;
    d.fd  = fd;
    done_q.push_back(d);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Snapshot monitor: compare queued expectations on the falling edge
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      if (e.cyc != cyc || state_dbg !== e.st || motor_l !== e.ml || motor_r !== e.mr ||
          busy !== e.bz || done !== e.dn || found !== e.fd) begin
        n_err++;
        $display("FAIL %s cyc=%0d(want %0d): got st=%0d ml=%b mr=%b busy=%b done=%b found=%b, expected st=%0d ml=%b mr=%b busy=%b done=%b found=%b",
                 e.nm, cyc, e.cyc, state_dbg, motor_l, motor_r, busy, done, found,
                 e.st, e.ml, e.mr, e.bz, e.dn, e.fd);
      end
    end
  end

  // Done-pulse monitor: every done must be one that was expected
  always @(negedge clk) begin
    done_t d;
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done cyc=%0d: got done=1 found=%b, expected no done pulse", cyc, found);
      end else begin
        d = done_q.pop_front();
        if (d.cyc != cyc || found !== d.fd) begin
          n_err++;
          $display("FAIL done_pulse: got cyc=%0d found=%b, expected cyc=%0d found=%b",
                   cyc, found, d.cyc, d.fd);
        end
      end
    end
  end

  initial begin
    int b;
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    freq_state   = 4'd0;
    target_state = 4'd0;

    // Reset state
    expect_at(2, "reset_state", S_IDLE, 1'b0, 1'b0, 1'b0);
    step(3);
    rst_n = 1'b1;
    expect_at(5, "idle_after_reset", S_IDLE, 1'b0, 1'b0, 1'b0);
    step(2);

    // Full successful search, target 9
    b = cyc;
    target_state = 4'd9;
    start = 1'b1;
    expect_at(b + 1,  "s1_scan",       S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 10, "s1_scan_last",  S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 11, "s1_confirm",    S_CONF, 1'b0, 1'b0, 1'b0);
    expect_at(b + 13, "s1_confirm3",   S_CONF, 1'b0, 1'b0, 1'b0);
    expect_at(b + 14, "s1_drive",      S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 63, "s1_drive_last", S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 64, "s1_done",       S_DONE, 1'b0, 1'b1, 1'b1);
    expect_at(b + 65, "s1_idle",       S_IDLE, 1'b0, 1'b0, 1'b1);
    expect_done(b + 64, 1'b1);
    step(1);
    start = 1'b0;
    step(9);
    freq_state = 4'd9;
    step(55);
    freq_state = 4'd0;
    step(2);

    // Start with out-of-range targets is ignored, found is retained
    b = cyc;
    target_state = 4'd3;
    start = 1'b1;
    expect_at(b + 1, "s6_ign_t3",  S_IDLE, 1'b0, 1'b0, 1'b1);
    expect_at(b + 2, "s6_ign_t15", S_IDLE, 1'b0, 1'b0, 1'b1);
    expect_at(b + 3, "s6_idle",    S_IDLE, 1'b0, 1'b0, 1'b1);
    step(1);
    target_state = 4'd15;
    step(1);
    start = 1'b0;
    step(2);

    // Scan timeout with no signal, target 12
    b = cyc;
    target_state = 4'd12;
    freq_state = 4'd0;
    start = 1'b1;
    expect_at(b + 1,   "s2_scan",     S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 50,  "s2_scan_mid", S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 100, "s2_scan_end", S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 101, "s2_done",     S_DONE, 1'b0, 1'b1, 1'b0);
    expect_at(b + 102, "s2_idle",     S_IDLE, 1'b0, 1'b0, 1'b0);
    expect_done(b + 101, 1'b0);
    step(1);
    start = 1'b0;
    step(103);

    // Confirm aborted after 2 matches; scan timer keeps counting
    b = cyc;
    target_state = 4'd10;
    start = 1'b1;
    expect_at(b + 5,   "s3_scan",     S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 6,   "s3_confirm",  S_CONF, 1'b0, 1'b0, 1'b0);
    expect_at(b + 7,   "s3_confirm2", S_CONF, 1'b0, 1'b0, 1'b0);
    expect_at(b + 8,   "s3_rescan",   S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 102, "s3_scan_end", S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 103, "s3_done",     S_DONE, 1'b0, 1'b1, 1'b0);
    expect_at(b + 104, "s3_idle",     S_IDLE, 1'b0, 1'b0, 1'b0);
    expect_done(b + 103, 1'b0);
    step(1);
    start = 1'b0;
    step(4);
    freq_state = 4'd10;
    step(2);
    freq_state = 4'd0;
    step(98);

    // Drive: 2 misses then match stays; 3 misses re-scan; then abort
    b = cyc;
    target_state = 4'd8;
    freq_state = 4'd8;
    start = 1'b1;
    expect_at(b + 1,  "s4_scan",      S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 2,  "s4_confirm",   S_CONF, 1'b0, 1'b0, 1'b0);
    expect_at(b + 5,  "s4_drive",     S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 9,  "s4_drive_m2",  S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 10, "s4_drive_hit", S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 12, "s4_drive_l1",  S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 13, "s4_drive_l2",  S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 14, "s4_rescan",    S_SCAN, TOG,  1'b0, 1'b0);
    expect_at(b + 15, "s4_abort_idle", S_IDLE, 1'b0, 1'b0, 1'b0);
    step(1);
    start = 1'b0;
    step(6);
    freq_state = 4'd0;
    step(2);
    freq_state = 4'd8;
    step(2);
    freq_state = 4'd0;
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(2);

    // Abort in DRIVE: no done pulse, found unchanged
    b = cyc;
    target_state = 4'd7;
    freq_state = 4'd7;
    start = 1'b1;
    expect_at(b + 5,  "s5_drive",   S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 7,  "s5_drive2",  S_DRV,  1'b0, 1'b0, 1'b0);
    expect_at(b + 8,  "s5_abort",   S_IDLE, 1'b0, 1'b0, 1'b0);
    expect_at(b + 10, "s5_idle",    S_IDLE, 1'b0, 1'b0, 1'b0);
    step(1);
    start = 1'b0;
    step(6);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    freq_state = 4'd0;
    step(3);

    // Reset mid-SCAN with start still asserted
    b = cyc;
    target_state = 4'd11;
    freq_state = 4'd0;
    start = 1'b1;
    expect_at(b + 3, "s7_scan",      S_SCAN, 1'b0, 1'b0, 1'b0);
    expect_at(b + 4, "s7_rst_idle",  S_IDLE, 1'b0, 1'b0, 1'b0);
    expect_at(b + 5, "s7_rst_hold",  S_IDLE, 1'b0, 1'b0, 1'b0);
    expect_at(b + 7, "s7_post_rst",  S_IDLE, 1'b0, 1'b0, 1'b0);
    step(3);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    start = 1'b0;
    step(5);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: got no check at cyc %0d, expected a check by cyc %0d", e.nm, e.cyc, cyc);
    end
    while (done_q.size() > 0) begin
      done_t d;
      d = done_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_done: got no done pulse, expected one at cyc %0d found=%b", d.cyc, d.fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
